// File: rtl/mac_seq.sv
// Operand sequencer for the mac unit: streams A row / B column pairs, collects each
// dot product and returns C = A*B row-major over a valid/ready result port.
module mac_seq #(
  parameter int DATA_W = 16,
  parameter int K      = 4,
  parameter int M      = 4,
  parameter int N      = 4,
  localparam int ACC_W  = 2*DATA_W + $clog2(K) + 1,
  localparam int A_SZ   = M*K,
  localparam int B_SZ   = K*N,
  localparam int MAX_SZ = (A_SZ > B_SZ) ? A_SZ : B_SZ,
  localparam int AW     = ($clog2(MAX_SZ) < 1) ? 1 : $clog2(MAX_SZ),
  localparam int RW     = $clog2(M) + 1,
  localparam int CW     = $clog2(N) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_en,
  input  logic                     ld_sel,
  input  logic [AW-1:0]            ld_addr,
  input  logic signed [DATA_W-1:0] ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  output logic                     mac_acc_clear,
  input  logic signed [ACC_W-1:0]  mac_acc_out,
  input  logic                     mac_acc_out_valid,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic [RW-1:0]            res_row,
  output logic [CW-1:0]            res_col
);

  localparam int KW  = $clog2(K) + 1;
  localparam int AAW = ($clog2(A_SZ) < 1) ? 1 : $clog2(A_SZ);
  localparam int BAW = ($clog2(B_SZ) < 1) ? 1 : $clog2(B_SZ);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, EMIT} state_t;

  state_t                   state_q, state_d;
  logic [RW-1:0]            i_q, i_d;
  logic [CW-1:0]            j_q, j_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     clr_q, clr_d;
  logic                     done_q, done_d;
  logic signed [ACC_W-1:0]  res_q, res_d;

  logic signed [DATA_W-1:0] a_mem [A_SZ];
  logic signed [DATA_W-1:0] b_mem [B_SZ];
  logic                     ld_ok_a, ld_ok_b;
  logic [AAW-1:0]           a_idx;
  logic [BAW-1:0]           b_idx;

  // Stores are frozen while a computation is running.
  assign ld_ok_a = ld_en && (state_q == IDLE) && !ld_sel && (int'(ld_addr) < A_SZ);
  assign ld_ok_b = ld_en && (state_q == IDLE) &&  ld_sel && (int'(ld_addr) < B_SZ);

  always_ff @(posedge clk) begin
    if (ld_ok_a) a_mem[ld_addr[AAW-1:0]] <= ld_data;
    if (ld_ok_b) b_mem[ld_addr[BAW-1:0]] <= ld_data;
  end

  assign a_idx = AAW'(int'(i_q) * K + int'(k_q));
  assign b_idx = BAW'(int'(k_q) * N + int'(j_q));

  // Operands are read combinationally so a load on the start edge is seen by FEED.
  assign mac_a = (state_q == FEED) ? a_mem[a_idx] : '0;
  assign mac_b = (state_q == FEED) ? b_mem[b_idx] : '0;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (k_q == '0) clr_d = 1'b1;
        if (k_q == KW'(K-1)) begin
          k_d     = '0;
          state_d = WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WAIT: begin
        // A valid seen alongside our own clear belongs to the previous element.
        if (mac_acc_out_valid && !clr_q) begin
          res_d   = mac_acc_out;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (res_ready) begin
          k_d = '0;
          if (j_q == CW'(N-1)) begin
            j_d = '0;
            if (i_q == RW'(M-1)) begin
              i_d     = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              i_d     = i_q + 1'b1;
              state_d = FEED;
            end
          end else begin
            j_d     = j_q + 1'b1;
            state_d = FEED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign mac_acc_clear = clr_q;
  assign res_valid     = (state_q == EMIT);
  assign res_data      = res_q;
  assign res_row       = i_q;
  assign res_col       = j_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a 4x4x4 and a 2x1x2 instance, each fed by a behavioural mac,
// results compared against plain matrix products.
module tb_mac_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              ld_en4 = 1'b0, ld_sel4 = 1'b0, start4 = 1'b0, rr4 = 1'b0;
  logic [3:0]        ld_addr4 = '0;
  logic signed [15:0] ld_data4 = '0;
  logic              busy4, done4, clr4, accv4, rv4;
  logic signed [15:0] a4, b4;
  logic signed [34:0] acc4, rd4;
  logic [2:0]        row4, col4;

  logic              ld_en1 = 1'b0, ld_sel1 = 1'b0, start1 = 1'b0, rr1 = 1'b0;
  logic [0:0]        ld_addr1 = '0;
  logic signed [15:0] ld_data1 = '0;
  logic              busy1, done1, clr1, accv1, rv1;
  logic signed [15:0] a1, b1;
  logic signed [32:0] acc1, rd1;
  logic [1:0]        row1, col1;

  mac_seq #(.DATA_W(16), .K(4), .M(4), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en4), .ld_sel(ld_sel4), .ld_addr(ld_addr4),
    .ld_data(ld_data4), .start(start4), .busy(busy4), .done(done4), .mac_a(a4), .mac_b(b4),
    .mac_acc_clear(clr4), .mac_acc_out(acc4), .mac_acc_out_valid(accv4), .res_valid(rv4),
    .res_ready(rr4), .res_data(rd4), .res_row(row4), .res_col(col4));

  mac_seq #(.DATA_W(16), .K(1), .M(2), .N(2)) u1 (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en1), .ld_sel(ld_sel1), .ld_addr(ld_addr1),
    .ld_data(ld_data1), .start(start1), .busy(busy1), .done(done1), .mac_a(a1), .mac_b(b1),
    .mac_acc_clear(clr1), .mac_acc_out(acc1), .mac_acc_out_valid(accv1), .res_valid(rv1),
    .res_ready(rr1), .res_data(rd1), .res_row(row1), .res_col(col1));

  // Behavioural mac: one product pipeline stage, the clear cycle loads the two newest
  // products, valid once K terms are in the sum and stays (stale) until the next clear.
  longint m4_acc, m4_prev, m1_acc, m1_prev;
  int     m4_cnt, m1_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_acc <= 0; m4_prev <= 0; m4_cnt <= 0;
      m1_acc <= 0; m1_prev <= 0; m1_cnt <= 0;
    end else begin
      m4_prev <= longint'(a4) * longint'(b4);
      if (clr4) begin
        m4_acc <= m4_prev + longint'(a4) * longint'(b4);
        m4_cnt <= 2;
      end else begin
        m4_acc <= m4_acc + longint'(a4) * longint'(b4);
        if (m4_cnt < 4) m4_cnt <= m4_cnt + 1;
      end
      m1_prev <= longint'(a1) * longint'(b1);
      if (clr1) begin
        m1_acc <= m1_prev + longint'(a1) * longint'(b1);
        m1_cnt <= 2;
      end else begin
        m1_acc <= m1_acc + longint'(a1) * longint'(b1);
        if (m1_cnt < 1) m1_cnt <= m1_cnt + 1;
      end
    end
  end
  assign acc4  = m4_acc[34:0];
  assign accv4 = (m4_cnt >= 4);
  assign acc1  = m1_acc[32:0];
  assign accv1 = (m1_cnt >= 1);

  int     q4r[$], q4c[$], q1r[$], q1c[$];
  longint q4d[$], q1d[$];
  int     clr4_n = 0, done4_n = 0, clr1_n = 0;
  always @(negedge clk) begin
    if (rv4 && rr4) begin
      q4r.push_back(int'(row4)); q4c.push_back(int'(col4)); q4d.push_back(longint'(rd4));
    end
    if (rv1 && rr1) begin
      q1r.push_back(int'(row1)); q1c.push_back(int'(col1)); q1d.push_back(longint'(rd1));
    end
    if (clr4)  clr4_n++;
    if (done4) done4_n++;
    if (clr1)  clr1_n++;
  end

  logic signed [15:0] A4 [4][4];
  logic signed [15:0] B4 [4][4];
  longint             C4 [4][4];
  logic signed [15:0] A1 [2];
  logic signed [15:0] B1 [2];
  longint             E1 [4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic sel, input int addr, input logic signed [15:0] d);
    ld_en4 = 1'b1; ld_sel4 = sel; ld_addr4 = 4'(addr); ld_data4 = d;
    tick();
    ld_en4 = 1'b0;
  endtask

  task automatic load1(input logic sel, input int addr, input logic signed [15:0] d);
    ld_en1 = 1'b1; ld_sel1 = sel; ld_addr1 = 1'(addr); ld_data1 = d;
    tick();
    ld_en1 = 1'b0;
  endtask

  task automatic compute4();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        C4[i][j] = 0;
        for (int k = 0; k < 4; k++) C4[i][j] += longint'(A4[i][k]) * longint'(B4[k][j]);
      end
  endtask

  task automatic check_c4(input int base, input string tag);
    chk({tag, "_count"}, q4d.size() - base, 16);
    for (int e = 0; e < 16; e++)
      if (base + e < q4d.size()) begin
        chk($sformatf("%s_c%0d%0d", tag, e/4, e%4), q4d[base+e], C4[e/4][e%4]);
        chk($sformatf("%s_idx%0d", tag, e), q4r[base+e]*4 + q4c[base+e], e);
      end
  endtask

  task automatic run4(input int exp_n, input string tag);
    int n = 0;
    start4 = 1'b1; rr4 = 1'b1;
    tick();
    start4 = 1'b0;
    while (!done4 && n < 1000) begin tick(); n++; end
    chk({tag, "_done"}, done4, 1);
    chk({tag, "_cycles"}, n, exp_n);
    tick();
    chk({tag, "_done_pulse"}, done4, 0);
  endtask

  task automatic run1_check(input string tag);
    int n = 0;
    int base = q1d.size();
    int cbase = clr1_n;
    start1 = 1'b1; rr1 = 1'b1;
    tick();
    start1 = 1'b0;
    while (!done1 && n < 1000) begin tick(); n++; end
    chk({tag, "_done"}, done1, 1);
    chk({tag, "_cycles"}, n, 16);
    chk({tag, "_clears"}, clr1_n - cbase, 4);
    chk({tag, "_count"}, q1d.size() - base, 4);
    for (int e = 0; e < 4; e++)
      if (base + e < q1d.size()) begin
        chk($sformatf("%s_c%0d%0d", tag, e/2, e%2), q1d[base+e], E1[e]);
        chk($sformatf("%s_idx%0d", tag, e), q1r[base+e]*2 + q1c[base+e], e);
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stall, base, dn, cbase;
    logic bsy_drop;
    logic signed [34:0] h_dat;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_valid4", rv4, 0);
    chk("rst_clear4", clr4, 0);
    chk("rst_mac_a4", a4, 0);
    chk("rst_mac_b4", b4, 0);
    chk("rst_data4", rd4, 0);
    chk("rst_rowcol4", {row4, col4}, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_data1", rd1, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 4x4x4: extreme row/column pairs plus random fill
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        A4[i][k] = 16'($urandom);
        B4[i][k] = 16'($urandom);
      end
    for (int k = 0; k < 4; k++) begin
      A4[0][k] = 16'sh8000;
      B4[k][0] = 16'sh8000;
      B4[k][1] = 16'sd1;
    end
    A4[1][0] = 16'sd32767; A4[1][1] = 16'sh8000; A4[1][2] = 16'sd1; A4[1][3] = -16'sd1;
    for (int a = 0; a < 15; a++) load4(1'b0, a, A4[a/4][a%4]);
    for (int a = 0; a < 16; a++) load4(1'b1, a, B4[a/4][a%4]);
    A4[3][3] = 16'($urandom);
    compute4();

    // last load shares its cycle with start
    cbase = clr4_n;
    ld_en4 = 1'b1; ld_sel4 = 1'b0; ld_addr4 = 4'd15; ld_data4 = A4[3][3];
    start4 = 1'b1; rr4 = 1'b1;
    tick();
    ld_en4 = 1'b0; start4 = 1'b0;
    base = q4d.size(); n = 0; stall = 0; bsy_drop = 1'b0; h_dat = '0;
    while (!done4 && n < 1000) begin
      if (rv4 && row4 == 3'd0 && col4 == 3'd1 && stall < 5) begin
        rr4 = 1'b0;
        if (stall == 0) h_dat = rd4;
        else begin
          chk("bp_hold_data", rd4, h_dat);
          chk("bp_no_clear", clr4, 0);
        end
        if (stall == 2) begin
          start4 = 1'b1;
          ld_en4 = 1'b1; ld_sel4 = 1'b0; ld_addr4 = 4'd0; ld_data4 = ~A4[0][0];
        end
        stall++;
      end else begin
        rr4 = 1'b1;
      end
      tick();
      start4 = 1'b0; ld_en4 = 1'b0;
      n++;
      if (!done4 && !busy4) bsy_drop = 1'b1;
    end
    chk("bp_stall_cycles", stall, 5);
    chk("bp_value", h_dat, C4[0][1]);
    chk("run1_done", done4, 1);
    chk("run1_cycles", n, 101);
    chk("run1_busy_held", bsy_drop, 0);
    tick();
    chk("run1_done_pulse", done4, 0);
    chk("run1_idle", busy4, 0);
    chk("run1_clears", clr4_n - cbase, 16);
    check_c4(base, "run1");
    if (q4d.size() >= base + 6) begin
      chk("c00_no_overflow", q4d[base], 64'sd4294967296);
      chk("c11_mixed", q4d[base+5], -64'sd1);
    end

    // reset in the first FEED cycle of element (1,0)
    dn = done4_n;
    start4 = 1'b1; rr4 = 1'b1;
    tick();
    start4 = 1'b0; n = 0;
    while (row4 != 3'd1 && n < 200) begin tick(); n++; end
    chk("abort_reach_row1", row4, 1);
    chk("abort_at_cycle", n, 24);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy4, 0);
    chk("abort_valid", rv4, 0);
    chk("abort_clear", clr4, 0);
    chk("abort_mac_a", a4, 0);
    chk("abort_mac_b", b4, 0);
    chk("abort_data", rd4, 0);
    chk("abort_rowcol", {row4, col4}, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("abort_no_done", done4_n - dn, 0);
    base = q4d.size();
    run4(96, "rerun");
    check_c4(base, "rerun");

    // K=1: directed values, then random
    A1[0] = 16'sd3; A1[1] = -16'sd2; B1[0] = 16'sd4; B1[1] = 16'sd5;
    load1(1'b0, 0, A1[0]); load1(1'b0, 1, A1[1]);
    load1(1'b1, 0, B1[0]); load1(1'b1, 1, B1[1]);
    E1[0] = 12; E1[1] = 15; E1[2] = -8; E1[3] = -10;
    run1_check("k1_dir");
    for (int x = 0; x < 2; x++) begin
      A1[x] = 16'($urandom);
      B1[x] = 16'($urandom);
      load1(1'b0, x, A1[x]);
      load1(1'b1, x, B1[x]);
    end
    for (int e = 0; e < 4; e++) E1[e] = longint'(A1[e/2]) * longint'(B1[e%2]);
    run1_check("k1_rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
